// File: rtl/memory_hs_be.sv
// memory_hs_be: single-port synchronous RAM with a valid/ready request port,
// per-byte write enables, an RD_LAT-deep read pipe and optional clear sweep.
// Ports: clk, rst (synchronous, active-high)
//        req_valid/req_ready/req_wr/req_addr/req_wdata/req_be : request side
//        rsp_valid/rsp_rdata : read response, one pulse per accepted read
//        busy : clear sweep in progress
module memory_hs_be #(
    parameter int                AWIDTH       = 5,
    parameter int                DWIDTH       = 8,
    parameter int                RD_LAT       = 1,
    parameter bit                CLEAR_ON_RST = 1'b1,
    parameter logic [DWIDTH-1:0] INIT_VAL     = '0,
    localparam int               NBYTES       = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    input  logic [NBYTES-1:0] req_be,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              busy
);

    localparam int                DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] LAST  = '1;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] cnt;
    logic              sweep_we;
    logic              wr_acc;
    logic              rd_acc;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [RD_LAT-1:0] vld;
    logic [DWIDTH-1:0] pd  [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_ON_RST ? S_CLEAR : S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_CLEAR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Outputs depend only on the state register, so req_ready has no
    // combinational path from req_valid.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        req_ready = 1'b0;
        sweep_we  = 1'b0;
        unique case (state)
            S_CLEAR: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                req_ready = 1'b1;
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    assign wr_acc = req_valid & req_ready & req_wr & ~rst;
    assign rd_acc = req_valid & req_ready & ~req_wr & ~rst;

    // Memory has no reset: with CLEAR_ON_RST=0 contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (sweep_we) begin
                mem[cnt] <= INIT_VAL;
            end else if (wr_acc) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (req_be[i]) begin
                        mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read data is snapshotted at accept; stages only load when a valid
    // entry moves in, so the last stage holds the last returned word.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pd[i] <= '0;
            end
        end else begin
            vld[0] <= rd_acc;
            if (rd_acc) begin
                pd[0] <= mem[req_addr];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    pd[i] <= pd[i-1];
                end
            end
        end
    end

    assign rsp_valid = vld[RD_LAT-1];
    assign rsp_rdata = pd[RD_LAT-1];

endmodule

// File: tb/tb_memory_hs_be.sv
// tb_memory_hs_be: directed and random stimulus for two memory_hs_be
// configurations, checked every cycle against an array/queue model.
module tb_memory_hs_be;

    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int A_LAT = 3;
    localparam int B_LAT = 1;

    typedef struct {
        int          due;
        logic [31:0] d;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_rst, a_valid, a_ready, a_wr, a_rsp_valid, a_busy;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wdata, a_rdata;
    logic [3:0]    a_be;

    logic          b_rst, b_valid, b_ready, b_wr, b_rsp_valid, b_busy;
    logic [AW-1:0] b_addr;
    logic [7:0]    b_wdata, b_rdata;
    logic [0:0]    b_be;

    memory_hs_be #(
        .AWIDTH(AW), .DWIDTH(32), .RD_LAT(A_LAT),
        .CLEAR_ON_RST(1'b1), .INIT_VAL(32'h0)
    ) u_a (
        .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_wr(a_wr), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .busy(a_busy)
    );

    memory_hs_be #(
        .AWIDTH(AW), .DWIDTH(8), .RD_LAT(B_LAT),
        .CLEAR_ON_RST(1'b0), .INIT_VAL(8'h0)
    ) u_b (
        .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_wr(b_wr), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .busy(b_busy)
    );

    logic [31:0] ma [DEPTH];
    logic [7:0]  mb [DEPTH];
    rsp_t        a_q[$];
    rsp_t        b_q[$];
    int          a_left;
    int          cyc;
    bit          a_chk, b_chk;
    logic [31:0] a_last, a_got;
    logic [7:0]  b_last, b_got;
    int          checks;
    int          failures;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        rsp_t r;
        bit   ev;
        @(posedge clk);
        cyc++;
        if (a_rst) begin
            a_q.delete();
            a_last = '0;
            a_left = DEPTH;
            a_chk  = 1'b1;
        end else if (a_left > 0) begin
            ma[DEPTH-a_left] = 32'h0;
            a_left--;
        end else if (a_valid) begin
            if (a_wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (a_be[i]) ma[a_addr][8*i +: 8] = a_wdata[8*i +: 8];
                end
            end else begin
                r.due = cyc + A_LAT - 1;
                r.d   = ma[a_addr];
                a_q.push_back(r);
            end
        end
        if (b_rst) begin
            b_q.delete();
            b_last = '0;
            b_chk  = 1'b1;
        end else if (b_valid) begin
            if (b_wr) begin
                if (b_be[0]) mb[b_addr] = b_wdata;
            end else begin
                r.due = cyc + B_LAT - 1;
                r.d   = {24'h0, mb[b_addr]};
                b_q.push_back(r);
            end
        end
        #1;
        if (a_chk) begin
            ev = (a_q.size() > 0) && (a_q[0].due == cyc);
            if (ev) begin
                r = a_q.pop_front();
                a_last = r.d;
            end
            chk("a_rsp_valid", {31'h0, a_rsp_valid}, {31'h0, ev});
            chk("a_rsp_rdata", a_rdata, a_last);
            chk("a_req_ready", {31'h0, a_ready}, {31'h0, a_left == 0});
            chk("a_busy", {31'h0, a_busy}, {31'h0, a_left > 0});
            if (a_rsp_valid === 1'b1) a_got = a_rdata;
        end
        if (b_chk) begin
            ev = (b_q.size() > 0) && (b_q[0].due == cyc);
            if (ev) begin
                r = b_q.pop_front();
                b_last = r.d[7:0];
            end
            chk("b_rsp_valid", {31'h0, b_rsp_valid}, {31'h0, ev});
            chk("b_rsp_rdata", {24'h0, b_rdata}, {24'h0, b_last});
            chk("b_req_ready", {31'h0, b_ready}, 32'h1);
            chk("b_busy", {31'h0, b_busy}, 32'h0);
            if (b_rsp_valid === 1'b1) b_got = b_rdata;
        end
    endtask

    task automatic a_op(bit wr, logic [AW-1:0] addr, logic [31:0] d,
                        logic [3:0] be);
        a_valid = 1'b1;
        a_wr    = wr;
        a_addr  = addr;
        a_wdata = d;
        a_be    = be;
        tick();
        a_valid = 1'b0;
        a_wr    = 1'b0;
    endtask

    task automatic b_op(bit wr, logic [AW-1:0] addr, logic [7:0] d);
        b_valid = 1'b1;
        b_wr    = wr;
        b_addr  = addr;
        b_wdata = d;
        b_be    = 1'b1;
        tick();
        b_valid = 1'b0;
        b_wr    = 1'b0;
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        a_chk    = 1'b0;
        b_chk    = 1'b0;
        a_left   = 0;
        a_got    = '0;
        b_got    = '0;
        a_last   = '0;
        b_last   = '0;
        a_rst = 1'b1; a_valid = 1'b0; a_wr = 1'b0; a_addr = '0;
        a_wdata = '0; a_be = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_wr = 1'b0; b_addr = '0;
        b_wdata = '0; b_be = '0;
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;

        // clear sweep length, then every word reads INIT_VAL
        n = 0;
        for (int k = 0; k < 40 && a_busy === 1'b1; k++) begin
            n++;
            tick();
        end
        chk("a_sweep_cycles", n, 32);
        a_got = 32'hFFFF_FFFF;
        for (int k = 0; k < DEPTH; k++) a_op(1'b0, k[AW-1:0], '0, '0);
        repeat (A_LAT) tick();
        chk("a_clear_value", a_got, 32'h0);

        // byte-enable merge
        a_op(1'b1, 5'd3, 32'hAABB_CCDD, 4'b1111);
        a_op(1'b1, 5'd3, 32'h1122_3344, 4'b0101);
        a_op(1'b0, 5'd3, '0, '0);
        repeat (A_LAT) tick();
        chk("a_be_merge", a_got, 32'hAA22_CC44);

        // all-zero byte enable is a no-op
        a_op(1'b1, 5'd3, 32'h0, 4'b0000);
        a_op(1'b0, 5'd3, '0, '0);
        repeat (A_LAT) tick();
        chk("a_be_none", a_got, 32'hAA22_CC44);

        // back-to-back reads, in order
        a_op(1'b1, 5'd0, 32'h0101_0101, 4'hF);
        a_op(1'b1, 5'd1, 32'h0202_0202, 4'hF);
        a_op(1'b1, 5'd2, 32'h0303_0303, 4'hF);
        a_op(1'b0, 5'd0, '0, '0);
        a_op(1'b0, 5'd1, '0, '0);
        a_op(1'b0, 5'd2, '0, '0);
        repeat (A_LAT) tick();
        chk("a_lat3_last", a_got, 32'h0303_0303);

        // read in flight dropped by reset; sweep restarts
        a_op(1'b0, 5'd1, '0, '0);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        repeat (A_LAT + 2) tick();
        chk("a_busy_after_rst", {31'h0, a_busy}, 32'h1);
        for (int k = 0; k < 40 && a_left > 0; k++) tick();

        // random traffic on a small address window
        for (int k = 0; k < 300; k++) begin
            a_valid = ($urandom % 4) != 0;
            a_wr    = $urandom % 2;
            a_addr  = AW'($urandom % 8);
            a_wdata = $urandom;
            a_be    = 4'($urandom);
            tick();
        end
        a_valid = 1'b0;
        repeat (A_LAT + 1) tick();

        // instance B: fill memory so every word is known
        for (int k = 0; k < DEPTH; k++) b_op(1'b1, k[AW-1:0], 8'($urandom));

        b_op(1'b1, 5'd7, 8'h5A);
        b_op(1'b0, 5'd7, 8'h00);
        chk("b_raw_new", {24'h0, b_got}, 32'h5A);
        b_op(1'b0, 5'd7, 8'h00);
        b_op(1'b1, 5'd7, 8'hA5);
        chk("b_war_old", {24'h0, b_got}, 32'h5A);
        b_op(1'b0, 5'd7, 8'h00);
        chk("b_after_war", {24'h0, b_got}, 32'hA5);

        // contents survive reset when the sweep is disabled
        b_op(1'b1, 5'd9, 8'h3C);
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        chk("b_ready_after_rst", {31'h0, b_ready}, 32'h1);
        b_op(1'b0, 5'd9, 8'h00);
        chk("b_keep_on_rst", {24'h0, b_got}, 32'h3C);

        for (int k = 0; k < 300; k++) begin
            b_valid = ($urandom % 4) != 0;
            b_wr    = $urandom % 2;
            b_addr  = AW'($urandom % 8);
            b_wdata = 8'($urandom);
            b_be    = 1'($urandom);
            b_rst   = ($urandom % 32) == 0;
            tick();
        end
        b_valid = 1'b0;
        b_rst   = 1'b0;
        repeat (B_LAT + 1) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
